// File: rtl/cordic_sqrt_arb.sv
// Round-robin arbiter that shares one sqrt unit between four requesters.
// It issues one operand at a time and returns a tagged result, or an error if the unit times out.
module cordic_sqrt_arb #(
  parameter int unsigned TMO = 63
) (
  input  logic        clk,
  input  logic        rstx,
  input  logic [3:0]  req,
  input  logic [63:0] req_din,
  output logic [3:0]  req_ack,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        sq_start,
  output logic [15:0] sq_din,
  input  logic        sq_busy,
  input  logic [15:0] sq_dout
);

  localparam logic [7:0] TMO_C = 8'(TMO);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_gnt;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic [3:0]  r_reqAck;
  logic        r_rspValid;
  logic [1:0]  r_rspId;
  logic [15:0] r_rspData;
  logic        r_rspErr;
  logic        r_sqStart;
  logic [15:0] r_sqDin;

  logic [1:0]  w_grantIdx;
  logic [15:0] w_dinSlice;

  // The downward search lets the nearest requester at or after r_ptr win.
  always_comb begin
    w_grantIdx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_grantIdx = r_ptr + 2'(k);
      end
    end
  end

  assign w_dinSlice = req_din[{w_grantIdx, 4'b0000} +: 16];

  // sq_busy is registered, so r_busy trails the unit by one cycle.
  // r_cnt != 0 skips the first WAIT cycle, before busy can be seen.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_gnt      <= 2'd0;
      r_cnt      <= 8'd0;
      r_busy     <= 1'b0;
      r_reqAck   <= 4'd0;
      r_rspValid <= 1'b0;
      r_rspId    <= 2'd0;
      r_rspData  <= 16'd0;
      r_rspErr   <= 1'b0;
      r_sqStart  <= 1'b0;
      r_sqDin    <= 16'd0;
    end else begin
      r_busy     <= sq_busy;
      r_reqAck   <= 4'd0;
      r_sqStart  <= 1'b0;
      r_rspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt     <= w_grantIdx;
            r_ptr     <= w_grantIdx + 2'd1;
            r_reqAck  <= 4'd1 << w_grantIdx;
            r_sqStart <= 1'b1;
            r_sqDin   <= w_dinSlice;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt != 8'd0 && !r_busy) begin
            r_rspValid <= 1'b1;
            r_rspId    <= r_gnt;
            r_rspData  <= sq_dout;
            r_rspErr   <= 1'b0;
            r_state    <= DONE;
          end else if (r_cnt == TMO_C) begin
            r_rspValid <= 1'b1;
            r_rspId    <= r_gnt;
            r_rspData  <= 16'd0;
            r_rspErr   <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ack   = r_reqAck;
  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;
  assign sq_start  = r_sqStart;
  assign sq_din    = r_sqDin;

endmodule

// File: tb/tb_cordic_sqrt_arb.sv
// Directed bench for cordic_sqrt_arb: main DUT with a 12-cycle sqrt stub,
// plus a TMO=8 DUT whose stub can hang to exercise the watchdog.
module tb_cordic_sqrt_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstx;
  logic [3:0]  req, req2;
  logic [63:0] din, din2;
  logic [3:0]  reqAck, reqAck2;
  logic        rspValid, rspValid2, rspErr, rspErr2;
  logic [1:0]  rspId, rspId2;
  logic [15:0] rspData, rspData2;
  logic        sqStart, sqStart2, sqBusy, sqBusy2;
  logic [15:0] sqDin, sqDin2, sqDout, sqDout2;
  logic [15:0] stubDin, stubDin2;
  logic [3:0]  stubCnt;
  logic        hang2;

  int nChecks = 0;
  int nErrors = 0;
  int ackCnt = 0;
  int rspCnt = 0;
  int ack3Cnt = 0;

  cordic_sqrt_arb dut (
    .clk(clk), .rstx(rstx), .req(req), .req_din(din),
    .req_ack(reqAck), .rsp_valid(rspValid), .rsp_id(rspId), .rsp_data(rspData),
    .rsp_err(rspErr), .sq_start(sqStart), .sq_din(sqDin),
    .sq_busy(sqBusy), .sq_dout(sqDout)
  );

  cordic_sqrt_arb #(.TMO(8)) dut2 (
    .clk(clk), .rstx(rstx), .req(req2), .req_din(din2),
    .req_ack(reqAck2), .rsp_valid(rspValid2), .rsp_id(rspId2), .rsp_data(rspData2),
    .rsp_err(rspErr2), .sq_start(sqStart2), .sq_din(sqDin2),
    .sq_busy(sqBusy2), .sq_dout(sqDout2)
  );

  // Main stub: busy for 12 cycles after each start, result is ~operand.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      sqBusy  <= 1'b0;
      stubCnt <= 4'd0;
      stubDin <= 16'd0;
    end else if (sqStart) begin
      sqBusy  <= 1'b1;
      stubCnt <= 4'd12;
      stubDin <= sqDin;
    end else if (stubCnt != 4'd0) begin
      stubCnt <= stubCnt - 4'd1;
      sqBusy  <= (stubCnt > 4'd1);
    end
  end
  assign sqDout = ~stubDin;

  // Watchdog stub: one-cycle busy normally, stuck busy while hang2 is set.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      sqBusy2  <= 1'b0;
      stubDin2 <= 16'd0;
    end else if (sqStart2) begin
      sqBusy2  <= 1'b1;
      stubDin2 <= sqDin2;
    end else if (!hang2) begin
      sqBusy2  <= 1'b0;
    end
  end
  assign sqDout2 = ~stubDin2;

  always @(negedge clk) begin
    if (!rstx) begin
      ackCnt = 0;
      rspCnt = 0;
    end else begin
      if (reqAck != 4'd0) ackCnt++;
      if (rspValid) rspCnt++;
      if (reqAck[3]) ack3Cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [3:0] r, input logic [63:0] d);
    if (sel) begin
      req2 = r;
      din2 = d;
    end else begin
      req = r;
      din = d;
    end
  endtask

  task automatic waitAck(input bit sel, input int budget, output logic [3:0] ack);
    logic [3:0] a;
    ack = 4'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      a = sel ? reqAck2 : reqAck;
      if (a != 4'd0) begin
        ack = a;
        return;
      end
    end
  endtask

  task automatic waitRsp(input bit sel, input int budget, output bit found,
                         output logic [1:0] id, output logic [15:0] data, output logic err);
    found = 1'b0;
    id    = 2'd0;
    data  = 16'd0;
    err   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel ? rspValid2 : rspValid) begin
        found = 1'b1;
        id    = sel ? rspId2 : rspId;
        data  = sel ? rspData2 : rspData;
        err   = sel ? rspErr2 : rspErr;
        return;
      end
    end
  endtask

  task automatic doReset();
    rstx = 1'b0;
    repeat (2) @(negedge clk);
    rstx = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", nErrors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0]  ack;
    logic [1:0]  id;
    logic [15:0] data, exp;
    logic        err;
    bit          found;
    int          n, lat, seen, a3;
    int          order[5] = '{0, 1, 2, 3, 0};

    rstx  = 1'b0;
    hang2 = 1'b0;
    applyStimulus(0, 4'd0, 64'd0);
    applyStimulus(1, 4'd0, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ctrl", {reqAck, rspValid, rspId, rspErr, sqStart}, 32'd0);
    checkOutput("rst_sqDin", sqDin, 32'd0);
    checkOutput("rst_rspData", rspData, 32'd0);
    rstx = 1'b1;
    @(negedge clk);

    // Single request: ack with start, result two cycles after busy falls.
    applyStimulus(0, 4'b0001, 64'h1234);
    waitAck(0, 10, ack);
    checkOutput("s1_ack", ack, 32'b0001);
    checkOutput("s1_sqStart", sqStart, 32'd1);
    checkOutput("s1_sqDin", sqDin, 32'h1234);
    applyStimulus(0, 4'd0, 64'h1234);
    @(negedge clk);
    checkOutput("s1_startPulse", sqStart, 32'd0);
    checkOutput("s1_sqDinHold", sqDin, 32'h1234);
    n = 0;
    while (!sqBusy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (sqBusy && n < 30) begin @(negedge clk); n++; end
    lat = 0;
    while (!rspValid && lat < 10) begin @(negedge clk); lat++; end
    checkOutput("s1_latency", lat, 32'd2);
    checkOutput("s1_rspId", rspId, 32'd0);
    checkOutput("s1_rspData", rspData, 32'hEDCB);
    checkOutput("s1_rspErr", rspErr, 32'd0);
    @(negedge clk);
    checkOutput("s1_validPulse", rspValid, 32'd0);
    checkOutput("s1_dataHold", rspData, 32'hEDCB);

    // All four held: rotation 0,1,2,3,0.
    doReset();
    applyStimulus(0, 4'b1111, 64'h0040_0030_0020_0010);
    for (int i = 0; i < 5; i++) begin
      waitAck(0, 20, ack);
      checkOutput($sformatf("s2_ack%0d", i), ack, 32'(4'd1 << order[i]));
      waitRsp(0, 40, found, id, data, err);
      exp = ~(16'h0010 * 16'(order[i] + 1));
      checkOutput($sformatf("s2_found%0d", i), found, 32'd1);
      checkOutput($sformatf("s2_id%0d", i), id, 32'(order[i]));
      checkOutput($sformatf("s2_data%0d", i), data, exp);
    end
    applyStimulus(0, 4'd0, 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("s2_ackCnt", ackCnt, 32'd5);
    checkOutput("s2_rspCnt", rspCnt, 32'd5);

    // Pointer at 2 with req=0011 wraps to 0 first.
    doReset();
    applyStimulus(0, 4'b0010, 64'h0000_0000_0077_0000);
    waitAck(0, 10, ack);
    checkOutput("s3_setupAck", ack, 32'b0010);
    applyStimulus(0, 4'd0, 64'd0);
    waitRsp(0, 40, found, id, data, err);
    checkOutput("s3_setupRsp", found, 32'd1);
    applyStimulus(0, 4'b0011, 64'h0000_0000_0002_0001);
    waitAck(0, 10, ack);
    checkOutput("s3_ackFirst", ack, 32'b0001);
    applyStimulus(0, 4'b0010, 64'h0000_0000_0002_0001);
    waitRsp(0, 40, found, id, data, err);
    checkOutput("s3_idFirst", id, 32'd0);
    waitAck(0, 10, ack);
    checkOutput("s3_ackSecond", ack, 32'b0010);
    applyStimulus(0, 4'd0, 64'd0);
    waitRsp(0, 40, found, id, data, err);
    checkOutput("s3_idSecond", id, 32'd1);
    checkOutput("s3_dataSecond", data, 32'hFFFD);

    // Watchdog on the TMO=8 instance, bracketed by normal runs.
    applyStimulus(1, 4'b0001, 64'h0005);
    waitAck(1, 10, ack);
    checkOutput("s4_ackA", ack, 32'b0001);
    applyStimulus(1, 4'd0, 64'd0);
    waitRsp(1, 20, found, id, data, err);
    checkOutput("s4_foundA", found, 32'd1);
    checkOutput("s4_errA", err, 32'd0);
    checkOutput("s4_dataA", data, 32'hFFFA);
    hang2 = 1'b1;
    applyStimulus(1, 4'b0010, 64'h0000_0000_1111_0000);
    waitAck(1, 10, ack);
    checkOutput("s4_ackB", ack, 32'b0010);
    applyStimulus(1, 4'd0, 64'd0);
    waitRsp(1, 40, found, id, data, err);
    checkOutput("s4_foundB", found, 32'd1);
    checkOutput("s4_errB", err, 32'd1);
    checkOutput("s4_dataB", data, 32'd0);
    checkOutput("s4_idB", id, 32'd1);
    hang2 = 1'b0;
    applyStimulus(1, 4'b0100, 64'h0000_00FF_0000_0000);
    waitAck(1, 10, ack);
    checkOutput("s4_ackC", ack, 32'b0100);
    applyStimulus(1, 4'd0, 64'd0);
    waitRsp(1, 20, found, id, data, err);
    checkOutput("s4_foundC", found, 32'd1);
    checkOutput("s4_errC", err, 32'd0);
    checkOutput("s4_dataC", data, 32'hFF00);
    checkOutput("s4_idC", id, 32'd2);

    // Reset during WAIT abandons the transaction.
    applyStimulus(0, 4'b0001, 64'hABCD);
    waitAck(0, 10, ack);
    checkOutput("s5_ack", ack, 32'b0001);
    applyStimulus(0, 4'd0, 64'd0);
    repeat (3) @(negedge clk);
    rstx = 1'b0;
    #1;
    checkOutput("s5_ctrlClear", {reqAck, rspValid, rspId, rspErr, sqStart}, 32'd0);
    checkOutput("s5_sqDinClear", sqDin, 32'd0);
    checkOutput("s5_rspDataClear", rspData, 32'd0);
    repeat (2) @(negedge clk);
    rstx = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rspValid) seen++;
    end
    checkOutput("s5_noRsp", seen, 32'd0);
    applyStimulus(0, 4'b0100, 64'h0000_0009_0000_0000);
    waitAck(0, 10, ack);
    checkOutput("s5_postAck", ack, 32'b0100);
    applyStimulus(0, 4'd0, 64'd0);
    waitRsp(0, 40, found, id, data, err);
    checkOutput("s5_postId", id, 32'd2);
    checkOutput("s5_postData", data, 32'hFFF6);

    // Requester 3 withdraws while requester 0 is in WAIT.
    a3 = ack3Cnt;
    applyStimulus(0, 4'b0001, 64'h0333_0000_0000_0100);
    waitAck(0, 10, ack);
    checkOutput("s6_ack", ack, 32'b0001);
    applyStimulus(0, 4'd0, 64'h0333_0000_0000_0100);
    repeat (3) @(negedge clk);
    applyStimulus(0, 4'b1000, 64'h0333_0000_0000_0100);
    repeat (3) @(negedge clk);
    applyStimulus(0, 4'd0, 64'd0);
    waitRsp(0, 40, found, id, data, err);
    checkOutput("s6_id", id, 32'd0);
    checkOutput("s6_data", data, 32'hFEFF);
    repeat (20) @(negedge clk);
    checkOutput("s6_noAck3", ack3Cnt - a3, 32'd0);
    checkOutput("s6_ackCnt", ackCnt, 32'd2);
    checkOutput("s6_rspCnt", rspCnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/cordic_sqrt_arb.md
CORDIC_SQRT_ARB -- requirements
Module: cordic_sqrt_arb

Interface
REQ-001 SHALL have parameter TMO, default 63, meaning the watchdog limit in cycles spent in WAIT; legal range 8..255.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-003 SHALL have port rstx, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port req, input, 4 bits: level request per requester; the requester holds it until its ack.
REQ-006 SHALL have port req_din, input, 64 bits: operand of requester i at bits [16i+15:16i], stable while req[i]=1.
REQ-007 SHALL have port req_ack, output, 4 bits: one-hot, one-cycle acceptance pulse.
REQ-008 SHALL have port rsp_valid, output, 1 bit: one-cycle result strobe.
REQ-009 SHALL have port rsp_id, output, 2 bits: index of the requester that owns the result.
REQ-010 SHALL have port rsp_data, output, 16 bits: square-root result.
REQ-011 SHALL have port rsp_err, output, 1 bit: watchdog abort flag, qualified by rsp_valid.
REQ-012 SHALL have port sq_start, output, 1 bit: start pulse to the shared sqrt unit.
REQ-013 SHALL have port sq_din, output, 16 bits: operand to the sqrt unit.
REQ-014 SHALL have port sq_busy, input, 1 bit: sqrt unit busy; it may first rise the cycle after sq_start.
REQ-015 SHALL have port sq_dout, input, 16 bits: sqrt unit result, valid when sq_busy=0 after a run.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, with all outputs registered.
REQ-017 IDLE: when any req bit is 1, SHALL grant per REQ-018, latch the grant index and req_din slice, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin over a 2-bit pointer ptr: the granted index is the first i with req[i]=1 searching ptr, ptr+1, ... mod 4.
REQ-019 On grant of index g, ptr SHALL become (g+1) mod 4.
REQ-020 ISSUE (exactly 1 cycle): sq_start=1, sq_din=latched operand, req_ack[g]=1, then go to WAIT.
REQ-021 WAIT: sq_busy SHALL be ignored in the first WAIT cycle; from the second cycle on, sq_busy=0 SHALL capture sq_dout and go to DONE.
REQ-022 WAIT SHALL count cycles in an 8-bit counter cleared on entry; on count==TMO with sq_busy still 1, SHALL go to DONE with the error set.
REQ-023 DONE (exactly 1 cycle): rsp_valid=1, rsp_id=g, rsp_data=captured value (0 on error), rsp_err=error; then go to IDLE.
REQ-024 Requests arriving during ISSUE, WAIT or DONE SHALL NOT be acked until the next IDLE.
REQ-025 Minimum spacing between successive sq_start pulses SHALL be 4 cycles.
REQ-026 A req bit dropped before its ack SHALL be treated as withdrawn, with no ack and no response.
REQ-027 sq_din, rsp_id and rsp_data SHALL hold their last values outside their strobes.
REQ-028 Exactly one rsp_valid SHALL follow every req_ack, in order.

Reset
REQ-029 On rstx=0, asynchronously: state=IDLE, ptr=0, counter=0; req_ack, rsp_valid, rsp_id, rsp_data, rsp_err, sq_start, sq_din all 0.
REQ-030 Reset mid-operation SHALL abandon the transaction with no response; the first post-reset grant SHALL follow REQ-018 from ptr=0.

Verification
REQ-031 The bench SHALL use a stub sqrt unit with sq_busy high for 12 cycles after sq_start and sq_dout=~sq_din.
REQ-032 Scenario: req=0001, din0=0x1234 -> req_ack=0001 with sq_start and sq_din=0x1234 together; rsp_valid two cycles after sq_busy falls with rsp_id=0, rsp_data=0xEDCB, rsp_err=0.
REQ-033 Scenario: req=1111 held continuously -> grants in order 0,1,2,3,0, one rsp_valid each, with rsp_id matching.
REQ-034 Scenario: ptr=2 and req=0011 -> grant 0 first, then 1.
REQ-035 Scenario: stub keeps sq_busy=1 forever, TMO=8 -> rsp_valid with rsp_err=1 and rsp_data=0; the next request is serviced normally.
REQ-036 Scenario: rstx pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid, and a later req=0100 is granted to index 2.
REQ-037 Scenario: req[3] raised then dropped while another transaction is in WAIT -> no ack to requester 3, and the response count equals the ack count.
